mem_access: RTL and testbench

- Memory stage of the SEQ Y86-64 processor; sits directly downstream of execute.
- Consumes execute's valE plus decode's valA, fetch's valP and icode.
- Performs the one 8-byte data-memory read or write that the instruction requires, over a req/ack bus, and returns valM and the updated status.
- Stalls the sequencer via busy/done until the access completes; flags address faults as ADR.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/mem_addr_sel.sv | 48 ++++
 rtl/mem_access.sv | 151 +++++++++++++++
 tb/tb_mem_access.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-stage state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_addr_sel.sv
// Combinational operation decode for the memory stage: picks address, write
// data and direction, and checks that the 8-byte access fits in memory.
module mem_addr_sel
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] addr,
  output logic [63:0] wdata,
  output logic        we,
  output logic        access,
  output logic        legal
);

  // Highest legal start address; the compare is unsigned so huge addresses
  // cannot wrap back into range.
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  always_comb begin
    addr   = valE;
    wdata  = valA;
    we     = 1'b0;
    access = 1'b0;
    unique case (icode)
      IRMMOVQ, IPUSHQ: begin
        we     = 1'b1;
        access = 1'b1;
      end
      ICALL: begin
        we     = 1'b1;
        access = 1'b1;
        wdata  = valP;
      end
      IMRMOVQ: access = 1'b1;
      IPOPQ, IRET: begin
        access = 1'b1;
        addr   = valA;
      end
      default: ;
    endcase
    legal = (addr <= LAST_OK);
  end

endmodule

// File: rtl/mem_access.sv
// SEQ Y86-64 memory stage: performs at most one 8-byte bus access per
// instruction over a req/ack bus and reports valM and the resulting status.
module mem_access
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic [2:0]  stat_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [63:0]      valm_q, valm_d;
  logic [2:0]       stat_q, stat_d;

  logic [63:0] sel_addr, sel_wdata;
  logic        sel_we, sel_access, sel_legal;

  mem_addr_sel #(
    .MEM_BYTES(MEM_BYTES)
  ) u_sel (
    .icode (icode),
    .valE  (valE),
    .valA  (valA),
    .valP  (valP),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .we    (sel_we),
    .access(sel_access),
    .legal (sel_legal)
  );

  // State register; everything returns to its reset value asynchronously so
  // mem_req drops the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      valm_q  <= '0;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (stat_in != SAOK || !sel_access || !sel_legal) state_d = ST_DONE;
          else                                              state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: status/valM hold unless an operation resolves.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (stat_in != SAOK) begin
            stat_d = stat_in;
          end else if (!sel_access) begin
            stat_d = SAOK;
          end else if (!sel_legal) begin
            stat_d = SADR;
          end else begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            we_d    = sel_we;
            cnt_d   = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          if (mem_err) begin
            stat_d = SADR;
          end else begin
            stat_d = SAOK;
            if (!we_q) valm_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) stat_d = SADR;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_req = (state_q == ST_ACCESS);
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign valM      = valm_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access with a bus responder and a
// behavioural model of the memory stage.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic [2:0]  stat_in;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack, ack_r, stray_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        busy, done;

  always #5 clk = ~clk;
  assign mem_ack = ack_r | stray_ack;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP), .stat_in(stat_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .valM(valM), .stat(stat), .busy(busy), .done(done)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    int          delay;
    logic        err;
    logic [63:0] rdata;
    bit          chk_len;
  } bus_t;

  typedef struct {
    logic [2:0]  stat;
    logic [63:0] valm;
    int          lat;
  } exp_t;

  typedef struct {
    string       nm;
    logic [63:0] act;
    logic [63:0] exp;
  } obs_t;

  bus_t bus_q[$];
  exp_t exp_q[$];
  obs_t chk_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [63:0] m_valm;
  logic [2:0]  m_stat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void obs(input string nm, input logic [63:0] act, input logic [63:0] exp);
    obs_t o;
    o.nm = nm;
    o.act = act;
    o.exp = exp;
    chk_q.push_back(o);
  endfunction

  task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: the only place comparisons are counted.
  always @(negedge clk) begin
    exp_t x;
    obs_t o;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        compare("spurious_done", 64'd1, 64'd0);
      end else begin
        x = exp_q.pop_front();
        compare("stat", 64'(stat), 64'(x.stat));
        compare("valM", valM, x.valm);
        compare("latency", 64'(cyc - start_cyc), 64'(x.lat));
      end
    end
    while (chk_q.size() > 0) begin
      o = chk_q.pop_front();
      compare(o.nm, o.act, o.exp);
    end
  end

  // Bus responder: acks each request after the planned number of wait cycles.
  initial begin
    bus_t p;
    int   n;
    bit   unstable;
    ack_r = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (bus_q.size() == 0) begin
          obs("unexpected_req", 64'd1, 64'd0);
          n = 0;
          while (mem_req === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
          end
        end else begin
          p = bus_q.pop_front();
          obs("bus_addr", mem_addr, p.addr);
          obs("bus_we", 64'(mem_we), 64'(p.we));
          if (p.we) obs("bus_wdata", mem_wdata, p.wdata);
          n = 0;
          unstable = 1'b0;
          while (mem_req === 1'b1 && n < 400) begin
            if (mem_addr !== p.addr || mem_we !== p.we) unstable = 1'b1;
            if (n == p.delay) begin
              ack_r = 1'b1;
              mem_rdata = p.rdata;
              mem_err = p.err;
            end else begin
              ack_r = 1'b0;
              mem_rdata = {$urandom, $urandom};
              mem_err = 1'b0;
            end
            n++;
            @(negedge clk);
          end
          ack_r = 1'b0;
          mem_err = 1'b0;
          obs("bus_stable", 64'(unstable), 64'd0);
          if (p.chk_len) obs("req_cycles", 64'(n), 64'((p.delay + 1 < 255) ? p.delay + 1 : 255));
        end
      end
    end
  end

  // Behavioural model of one instruction, then drive it.
  task automatic run(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                     input logic [63:0] pv, input logic [2:0] si, input int dly,
                     input logic err, input logic [63:0] rd, input bit dup);
    bit          acc, wr;
    logic [63:0] ad, wd;
    exp_t        x;
    bus_t        b;
    int          lat, n;
    acc = 1'b0;
    wr = 1'b0;
    ad = e;
    wd = a;
    case (ic)
      4'h4, 4'hA: begin acc = 1'b1; wr = 1'b1; end
      4'h8:       begin acc = 1'b1; wr = 1'b1; wd = pv; end
      4'h5:       acc = 1'b1;
      4'h9, 4'hB: begin acc = 1'b1; ad = a; end
      default: ;
    endcase
    lat = 1;
    if (si != 3'd1) begin
      m_stat = si;
    end else if (!acc) begin
      m_stat = 3'd1;
    end else if ({1'b0, ad} + 65'd8 > 65'd8192) begin
      m_stat = 3'd3;
    end else begin
      b.addr = ad; b.wdata = wd; b.we = wr; b.delay = dly;
      b.err = err; b.rdata = rd; b.chk_len = 1'b1;
      bus_q.push_back(b);
      if (dly >= 255) begin
        m_stat = 3'd3;
        lat = 256;
      end else begin
        lat = dly + 2;
        if (err) m_stat = 3'd3;
        else begin
          m_stat = 3'd1;
          if (!wr) m_valm = rd;
        end
      end
    end
    x.stat = m_stat;
    x.valm = m_valm;
    x.lat = lat;
    exp_q.push_back(x);

    @(negedge clk);
    icode = ic; valE = e; valA = a; valP = pv; stat_in = si;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    valE = {$urandom, $urandom};
    valA = {$urandom, $urandom};
    valP = {$urandom, $urandom};
    if (dup && busy === 1'b1) begin
      icode = 4'h6;
      stat_in = 3'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) obs("done_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [63:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return 64'({$urandom_range(0, 1023), 3'b000});
    else if (r == 6) return 64'd8184;
    else if (r == 7) return 64'd8185;
    else if (r == 8) return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    else             return {$urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ic;
    logic [2:0] si;
    int         dly;
    rst_n = 1'b0;
    start = 1'b0;
    stray_ack = 1'b0;
    icode = '0; valE = '0; valA = '0; valP = '0; stat_in = 3'd1;
    m_valm = '0;
    m_stat = 3'd1;
    repeat (2) @(negedge clk);
    obs("rst_req", 64'(mem_req), 64'd0);
    obs("rst_done", 64'(done), 64'd0);
    obs("rst_busy", 64'(busy), 64'd0);
    obs("rst_valM", valM, 64'd0);
    obs("rst_stat", 64'(stat), 64'd1);
    obs("rst_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'h5, 64'h100, 64'h0, 64'h0, 3'd1, 2, 1'b0, 64'hDEADBEEF, 1'b0);
    run(4'h8, 64'h1F8, 64'h1234, 64'h40, 3'd1, 0, 1'b0, 64'h5555, 1'b0);
    run(4'h4, 64'd8190, 64'h77, 64'h0, 3'd1, 0, 1'b0, 64'h0, 1'b0);
    run(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 64'h0, 3'd1, 0, 1'b0, 64'h0, 1'b0);
    run(4'hB, 64'h0, 64'h80, 64'h0, 3'd1, 100000, 1'b0, 64'h0, 1'b0);
    run(4'h6, 64'h0, 64'h0, 64'h0, 3'd1, 0, 1'b0, 64'h0, 1'b1);
    run(4'h0, 64'h0, 64'h0, 64'h0, 3'd2, 0, 1'b0, 64'h0, 1'b1);
    run(4'h5, 64'd8184, 64'h0, 64'h0, 3'd1, 1, 1'b1, 64'hBAD, 1'b1);
    run(4'h9, 64'h0, 64'd8184, 64'h0, 3'd1, 0, 1'b0, 64'hCAFE, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ic = 4'($urandom_range(0, 15));
      si = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      dly = ($urandom_range(0, 24) == 0) ? 300 : int'($urandom_range(0, 4));
      run(ic, pick_addr(), pick_addr(), {$urandom, $urandom}, si, dly,
          ($urandom_range(0, 5) == 0), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
    end

    // Reset during an access, then a stray ack must not complete anything.
    begin
      bus_t b;
      b.addr = 64'h100; b.wdata = '0; b.we = 1'b0; b.delay = 100000;
      b.err = 1'b0; b.rdata = '0; b.chk_len = 1'b0;
      bus_q.push_back(b);
    end
    @(negedge clk);
    icode = 4'h5; valE = 64'h100; stat_in = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs("arst_req", 64'(mem_req), 64'd0);
    obs("arst_busy", 64'(busy), 64'd0);
    obs("arst_valM", valM, 64'd0);
    obs("arst_stat", 64'(stat), 64'd1);
    obs("arst_addr", mem_addr, 64'd0);
    obs("arst_we", 64'(mem_we), 64'd0);
    m_valm = '0;
    m_stat = 3'd1;
    @(negedge clk);
    rst_n = 1'b1;
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs("stray_ack_done", 64'(done), 64'd0);
      obs("stray_ack_req", 64'(mem_req), 64'd0);
    end
    stray_ack = 1'b0;

    run(4'h5, 64'h40, 64'h0, 64'h0, 3'd1, 0, 1'b0, 64'h1122_3344_5566_7788, 1'b0);
    repeat (2) @(negedge clk);
    obs("bus_plans_left", 64'(bus_q.size()), 64'd0);
    obs("expects_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
